// File: rtl/otp_emu_if.sv
// Core-to-OTP macro pin bundle: the core drives requests (master), the fuse
// emulation answers with data, status and pulses (slave).
interface otp_emu_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          otp_cs;
  logic          otp_read;
  logic          otp_prog;
  logic [AW-1:0] otp_addr;
  logic [DW-1:0] otp_dati;
  logic [DW-1:0] otp_dato;
  logic          otp_busy;
  logic          otp_rdvld;
  logic          otp_pdone;
  logic          otp_err;
  logic          otp_lock;

  modport master (
    output otp_cs, otp_read, otp_prog, otp_addr, otp_dati,
    input  otp_dato, otp_busy, otp_rdvld, otp_pdone, otp_err, otp_lock
  );

  modport slave (
    input  otp_cs, otp_read, otp_prog, otp_addr, otp_dati,
    output otp_dato, otp_busy, otp_rdvld, otp_pdone, otp_err, otp_lock
  );
endinterface

// File: rtl/otp_emu.sv
// Behavioural OTP fuse macro for FPGA builds: fixed-latency reads, timed
// bit-set-only program cycles, a lock fuse in the top word and a sticky error flag.
module otp_emu #(
  parameter int AW       = 6,
  parameter int DW       = 8,
  parameter int RD_LAT   = 2,
  parameter int PROG_CYC = 64
) (
  input logic       clk,
  input logic       rst,
  otp_emu_if.slave  bus
);
  localparam int            CW        = 16;
  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] LOCK_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    PROG = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r;
  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] addr_r;
  logic [DW-1:0] dati_r;
  logic [DW-1:0] dato_r;
  logic [CW-1:0] cnt_r;
  logic          rdvld_r;
  logic          pdone_r;
  logic          err_r;

  logic          lock_s;
  logic          rd_req_s;
  logic          pg_req_s;
  logic          bad_req_s;

  // Request decode and lock fuse tap
  always_comb begin
    lock_s    = mem_r[LOCK_ADDR][DW-1];
    rd_req_s  = bus.otp_cs & bus.otp_read & ~bus.otp_prog;
    pg_req_s  = bus.otp_cs & bus.otp_prog & ~bus.otp_read;
    bad_req_s = bus.otp_cs & bus.otp_read & bus.otp_prog;
  end

  // Access FSM, fuse array and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      addr_r  <= {AW{1'b0}};
      dati_r  <= {DW{1'b0}};
      dato_r  <= {DW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      rdvld_r <= 1'b0;
      pdone_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      rdvld_r <= 1'b0;
      pdone_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bad_req_s) begin
            err_r <= 1'b1;
          end else if (rd_req_s) begin
            addr_r  <= bus.otp_addr;
            cnt_r   <= CW'(RD_LAT - 1);
            state_r <= READ;
          end else if (pg_req_s) begin
            // A blown lock fuse freezes the whole array, lock word included
            if (lock_s) begin
              err_r <= 1'b1;
            end else begin
              addr_r  <= bus.otp_addr;
              dati_r  <= bus.otp_dati;
              cnt_r   <= CW'(PROG_CYC - 1);
              state_r <= PROG;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (cnt_r == {CW{1'b0}}) begin
            dato_r  <= mem_r[addr_r];
            rdvld_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        PROG: begin
          if (!bus.otp_cs) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
          end else if (cnt_r == {CW{1'b0}}) begin
            mem_r[addr_r] <= mem_r[addr_r] | dati_r;
            state_r       <= DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DONE: begin
          pdone_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.otp_dato  = dato_r;
  assign bus.otp_busy  = (state_r != IDLE);
  assign bus.otp_rdvld = rdvld_r;
  assign bus.otp_pdone = pdone_r;
  assign bus.otp_err   = err_r;
  assign bus.otp_lock  = lock_s;
endmodule

// File: tb/tb_otp_emu.sv
// Scoreboard bench for otp_emu: read data expectations are queued at issue
// and compared when rdvld fires; timing and status checked inline.
module tb_otp_emu;
  localparam int AW       = 6;
  localparam int DW       = 8;
  localparam int RD_LAT   = 2;
  localparam int PROG_CYC = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  otp_emu_if #(.AW(AW), .DW(DW)) bus ();

  otp_emu #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .PROG_CYC(PROG_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] mem_m [1 << AW];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.otp_cs   = 1'b0;
    bus.otp_read = 1'b0;
    bus.otp_prog = 1'b0;
    bus.otp_addr = 6'd0;
    bus.otp_dati = 8'd0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = 8'd0;
    exp_q.delete();
  endtask

  task automatic check_reset_outs(input string p);
    chk({p, "_dato"},  bus.otp_dato,  0);
    chk({p, "_busy"},  bus.otp_busy,  0);
    chk({p, "_rdvld"}, bus.otp_rdvld, 0);
    chk({p, "_pdone"}, bus.otp_pdone, 0);
    chk({p, "_err"},   bus.otp_err,   0);
    chk({p, "_lock"},  bus.otp_lock,  0);
  endtask

  task automatic apply_reset();
    idle_bus();
    rst = 1'b1;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_outs("rst");
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int k;
    int busy_n;
    exp_q.push_back(mem_m[a]);
    bus.otp_cs   = 1'b1;
    bus.otp_read = 1'b1;
    bus.otp_addr = a;
    tick();
    chk("rd_accept_busy", bus.otp_busy, 1);
    bus.otp_cs   = 1'b0;
    bus.otp_read = 1'b0;
    busy_n = 1;
    k = 0;
    while (k < 20 && bus.otp_rdvld !== 1'b1) begin
      tick();
      k++;
      if (bus.otp_busy === 1'b1) busy_n++;
    end
    chk("rd_latency", k, RD_LAT);
    chk("rd_busy_cycles", busy_n, RD_LAT);
    tick();
    chk("rd_pulse_width", bus.otp_rdvld, 0);
  endtask

  task automatic do_prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    bus.otp_cs   = 1'b1;
    bus.otp_prog = 1'b1;
    bus.otp_addr = a;
    bus.otp_dati = d;
    tick();
    chk("pg_accept_busy", bus.otp_busy, 1);
    bus.otp_prog = 1'b0;
    k = 0;
    while (k < PROG_CYC + 10 && bus.otp_pdone !== 1'b1) begin
      tick();
      k++;
    end
    chk("pg_latency", k, PROG_CYC + 1);
    chk("pg_busy_end", bus.otp_busy, 0);
    bus.otp_cs = 1'b0;
    mem_m[a] = mem_m[a] | d;
    tick();
    chk("pg_pulse_width", bus.otp_pdone, 0);
  endtask

  // Read data scoreboard: pop one expectation per rdvld pulse
  always @(posedge clk) begin
    #1;
    if (bus.otp_rdvld === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_rdvld", 1, 0);
      else chk("rd_data", bus.otp_dato, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic pd_seen;
    idle_bus();
    rst = 1'b1;
    clear_model();
    apply_reset();

    // Fresh read, then OR-accumulating programs
    do_read(6'h05);
    do_prog(6'h05, 8'h3C);
    do_read(6'h05);
    do_prog(6'h05, 8'h81);
    do_read(6'h05);
    chk("no_err_after_progs", bus.otp_err, 0);

    // Simultaneous read and prog is illegal
    bus.otp_cs   = 1'b1;
    bus.otp_read = 1'b1;
    bus.otp_prog = 1'b1;
    bus.otp_addr = 6'h05;
    bus.otp_dati = 8'hFF;
    tick();
    chk("ill_err", bus.otp_err, 1);
    chk("ill_busy", bus.otp_busy, 0);
    idle_bus();
    tick();
    chk("ill_busy_after", bus.otp_busy, 0);
    chk("ill_no_rdvld", bus.otp_rdvld, 0);
    do_read(6'h05);

    // Abort by dropping cs mid-program
    apply_reset();
    bus.otp_cs   = 1'b1;
    bus.otp_prog = 1'b1;
    bus.otp_addr = 6'h02;
    bus.otp_dati = 8'h0F;
    tick();
    chk("ab_accept_busy", bus.otp_busy, 1);
    bus.otp_prog = 1'b0;
    pd_seen = 1'b0;
    repeat (10) begin
      tick();
      pd_seen = pd_seen | bus.otp_pdone;
    end
    bus.otp_cs = 1'b0;
    tick();
    chk("ab_busy", bus.otp_busy, 0);
    chk("ab_err", bus.otp_err, 1);
    repeat (PROG_CYC + 5) begin
      pd_seen = pd_seen | bus.otp_pdone;
      tick();
    end
    chk("ab_no_pdone", pd_seen, 0);
    do_read(6'h02);

    // Reset in the middle of a program cycle
    apply_reset();
    bus.otp_cs   = 1'b1;
    bus.otp_prog = 1'b1;
    bus.otp_addr = 6'h07;
    bus.otp_dati = 8'hAA;
    tick();
    chk("mr_accept_busy", bus.otp_busy, 1);
    bus.otp_prog = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    #1;
    check_reset_outs("mr_async");
    idle_bus();
    clear_model();
    tick();
    rst = 1'b0;
    pd_seen = 1'b0;
    repeat (PROG_CYC + 5) begin
      tick();
      pd_seen = pd_seen | bus.otp_pdone;
    end
    chk("mr_no_pdone", pd_seen, 0);
    check_reset_outs("mr_after");
    do_read(6'h07);

    // Lock fuse blocks further programming
    do_prog(6'h3F, 8'h80);
    chk("lock_set", bus.otp_lock, 1);
    chk("lock_no_err", bus.otp_err, 0);
    bus.otp_cs   = 1'b1;
    bus.otp_prog = 1'b1;
    bus.otp_addr = 6'h10;
    bus.otp_dati = 8'hFF;
    tick();
    chk("locked_err", bus.otp_err, 1);
    chk("locked_busy", bus.otp_busy, 0);
    idle_bus();
    tick();
    chk("locked_busy_after", bus.otp_busy, 0);
    do_read(6'h10);
    do_read(6'h3F);
    chk("lock_held", bus.otp_lock, 1);

    repeat (4) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/otp_emu.md
# otp_emu

FPGA-side behavioural emulation of the one-time-programmable fuse macro that the mic_dc_top core drives through its OTP_CS/OTP_READ/OTP_PROG/OTP_ADDR/OTP_DATI/OTP_DATO pins. It sits directly downstream of the core in the FPGA top, replacing the silicon OTP. It gives the core a registered read path with fixed latency and a timed program cycle with fuse (bit-set-only) semantics. A lock fuse and error flag let trim/calibration flows be exercised on the board.

## Interface

- AW, 6, address width; array depth is 2^AW words
- DW, 8, data width
- RD_LAT, 2, read latency in clk cycles from accepted request to data valid (1..15)
- PROG_CYC, 64, program pulse length in clk cycles (2..65535)
- clk  in  1  system clock (same clock as the core's OTP interface)
- rst  in  1  asynchronous, active-high reset
- otp_cs  in  1  macro select; a request is considered only while high
- otp_read  in  1  read request level
- otp_prog  in  1  program request level
- otp_addr  in  AW  word address
- otp_dati  in  DW  program data; 1 bits are fuses to blow
- otp_dato  out  DW  read data, held between reads
- otp_busy  out  1  high while a read or program is in progress
- otp_rdvld  out  1  one-cycle pulse when otp_dato is updated
- otp_pdone  out  1  one-cycle pulse when a program cycle completes normally
- otp_err  out  1  sticky error flag, cleared only by rst
- otp_lock  out  1  current value of the lock fuse (bit DW-1 of address 2^AW-1)

## Operation

- Storage is 2^AW x DW flops, all cleared to 0 (unblown) on rst. Contents persist across idle periods, not across rst.
- FSM states: IDLE, READ, PROG, DONE.
- IDLE: sample at each clk edge.
  - cs & read & !prog -> latch addr, go to READ, counter = RD_LAT-1.
  - cs & prog & !read -> go to PROG if not rejected.
    - Rejected when lock = 1 and addr != 2^AW-1, or always when lock = 1 and the lock word itself is targeted: set err, stay IDLE.
    - Otherwise latch addr and dati, counter = PROG_CYC-1.
  - cs & read & prog -> illegal: set err, stay IDLE, no access.
  - cs low -> no action.
- READ: counter decrements each cycle. At 0, load otp_dato = mem[addr], pulse rdvld, go to IDLE. cs/read changes during READ are ignored.
- PROG: counter decrements each cycle; cs, prog and dati are ignored except as follows.
  - cs falling to 0 before the counter reaches 0 -> abort: no write, set err, go to IDLE.
  - At 0: mem[addr] <= mem[addr] | dati_latched (bits never clear), go to DONE.
- DONE: pulse pdone, go to IDLE. Requests are not sampled in DONE.
- otp_lock = mem[2^AW-1][DW-1], combinational from the array.
- otp_busy = (state != IDLE).

## Timing

- Reset values: otp_dato = 0, busy = 0, rdvld = 0, pdone = 0, err = 0, lock = 0, state = IDLE.
- Read accepted at edge N:
  - busy is high from edge N.
  - otp_dato is updated and rdvld is high for the cycle following edge N+RD_LAT.
  - busy falls at edge N+RD_LAT.
  - The next request can be sampled at edge N+RD_LAT+1 at the earliest.
- Program accepted at edge N:
  - busy is high from edge N.
  - The write occurs at edge N+PROG_CYC.
  - pdone is high for the cycle following edge N+PROG_CYC+1, and busy falls at that edge.
  - A read of the same address issued immediately afterwards returns the new value.
- Abort: cs sampled low at edge M inside PROG -> state = IDLE and err = 1 at edge M. No pdone.
- Reset asserted mid-operation clears the state and the array immediately. No pulse is generated.
- Requests held high across completion are re-sampled in IDLE as new requests (level protocol). The core must drop read/prog after rdvld/pdone.

## Test plan

- Reset then read addr 0x05, RD_LAT = 2 -> otp_dato = 0x00, rdvld pulses exactly 2 cycles after acceptance, busy high for 2 cycles.
- Program 0x05 with 0x3C, then read 0x05 -> pdone after PROG_CYC+1 cycles, read returns 0x3C. Program 0x05 again with 0x81, read -> 0xBD (OR semantics).
- Program addr 0x3F with 0x80 (lock) -> otp_lock = 1. Then program 0x10 with 0xFF -> err = 1, no busy, read 0x10 returns 0x00.
- Assert read and prog together with cs high -> err = 1, busy stays 0, array unchanged.
- Program 0x02 with 0x0F and drop cs after 10 cycles -> err = 1, no pdone, read 0x02 returns 0x00.
- Program 0x07 with 0xAA and assert rst at cycle 30 -> all outputs return to reset values, read 0x07 returns 0x00.
